// File: rtl/wb_timer_pkg.sv
// Shared register map, CTRL/STATUS bit positions and constants for wb_timer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package wb_timer_pkg;

    // Register offsets within the 8-word Wishbone window (adr_i[2:0]).
    localparam logic [2:0] OFS_CTRL     = 3'd0;
    localparam logic [2:0] OFS_PRESCALE = 3'd1;
    localparam logic [2:0] OFS_LOAD0    = 3'd2;
    localparam logic [2:0] OFS_COUNT0   = 3'd3;
    localparam logic [2:0] OFS_LOAD1    = 3'd4;
    localparam logic [2:0] OFS_COUNT1   = 3'd5;
    localparam logic [2:0] OFS_STATUS   = 3'd6;
    localparam logic [2:0] OFS_ID       = 3'd7;

    // CTRL bit positions: each channel owns an {auto, en} bit pair.
    localparam int CTRL_EN0   = 0;
    localparam int CTRL_AUTO0 = 1;
    localparam int CTRL_EN1   = 2;
    localparam int CTRL_AUTO1 = 3;

    // STATUS bit positions (write-1-to-clear expiry flags).
    localparam int STATUS_EXP0 = 0;
    localparam int STATUS_EXP1 = 1;

    localparam logic [31:0] TIMER_ID   = 32'h0000_7133;
    localparam int          NUM_CHAN   = 2;
    localparam int          PRESCALE_W = 16;

    // Per-channel control bits as held by the channel.
    typedef struct packed {
        logic auto_rl;  // reload COUNT from LOAD on expiry instead of stopping
        logic en;       // channel counts on prescaler ticks
    } chan_ctrl_t;

    // CTRL bit index of a channel's enable / auto-reload bit.
    function automatic int ctrl_en_bit(input int ch);
        return 2 * ch;
    endfunction

    function automatic int ctrl_auto_bit(input int ch);
        return 2 * ch + 1;
    endfunction

endpackage

// File: rtl/wb_timer_chan.sv
// One timer channel: LOAD/COUNT registers, en/auto control and expiry detection.
// Latency: expire is combinational on the tick cycle; register updates land on the next edge.
// Backpressure: none; bus writes always take priority over hardware updates.
//
// Ports:
//   clk, arst          clock, asynchronous active-high reset
//   tick               one-cycle prescaler tick
//   ctrl_we, ctrl_dat  CTRL write strobe and this channel's {auto, en} bits
//   load_we, load_dat  LOAD write strobe and data (also written into COUNT)
//   ctrl, load, count  current register contents for read-back
//   expire             high in the cycle where a tick hits COUNT == 0 while enabled
module wb_timer_chan
    import wb_timer_pkg::*;
#(
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             tick,
    input  logic             ctrl_we,
    input  chan_ctrl_t       ctrl_dat,
    input  logic             load_we,
    input  logic [WIDTH-1:0] load_dat,
    output chan_ctrl_t       ctrl,
    output logic [WIDTH-1:0] load,
    output logic [WIDTH-1:0] count,
    output logic             expire
);

    assign expire = tick && ctrl.en && (count == '0);

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            ctrl  <= '0;
            load  <= '0;
            count <= '0;
        end else begin
            // A CTRL write overrides the one-shot self-disable in the same cycle.
            if (ctrl_we) begin
                ctrl <= ctrl_dat;
            end else if (expire && !ctrl.auto_rl) begin
                ctrl.en <= 1'b0;
            end

            // A LOAD write sets both LOAD and COUNT and overrides any
            // same-cycle reload or decrement.
            if (load_we) begin
                load  <= load_dat;
                count <= load_dat;
            end else if (expire) begin
                if (ctrl.auto_rl) begin
                    count <= load;
                end
            end else if (tick && ctrl.en) begin
                count <= count - WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/wb_timer.sv
// Two-channel down-counting timer with a shared 16-bit prescaler on a Wishbone slave port.
// Latency: ack_o and registered read data one cycle after a selected strobe; irq_o one cycle after expiry.
// Backpressure: none beyond the single-cycle ack; a strobe held through its ack cycle is not re-acked.
//
// Ports:
//   clk, arst            clock, asynchronous active-high reset
//   adr_i [14:0]         word address; selected when adr_i[14:3] == BASE[14:3]
//   dat_i / dat_o [31:0] write data / registered read data (0 when ack_o is low)
//   we_i, stb_i, ack_o   Wishbone write enable, strobe and acknowledge
//   irq_o [1:0]          one-cycle expiry pulse per channel
module wb_timer
    import wb_timer_pkg::*;
#(
    parameter logic [14:0] BASE  = 15'h7F00,
    parameter int          WIDTH = 24        // 1..32
) (
    input  logic        clk,
    input  logic        arst,
    input  logic [14:0] adr_i,
    input  logic [31:0] dat_i,
    output logic [31:0] dat_o,
    input  logic        we_i,
    input  logic        stb_i,
    output logic        ack_o,
    output logic [1:0]  irq_o
);

    // ---------------------------------------------------------------
    // Bus decode
    // ---------------------------------------------------------------
    logic       sel;
    logic       acc;     // transaction accepted this cycle (ack rises next edge)
    logic       wr_stb;
    logic       rd_stb;
    logic [2:0] ofs;

    assign sel    = stb_i && (adr_i[14:3] == BASE[14:3]);
    assign acc    = sel && !ack_o;
    assign wr_stb = acc && we_i;
    assign rd_stb = acc && !we_i;
    assign ofs    = adr_i[2:0];

    logic                ctrl_we;
    logic                psc_we;
    logic                stat_we;
    logic [NUM_CHAN-1:0] load_we;

    assign ctrl_we = wr_stb && (ofs == OFS_CTRL);
    assign psc_we  = wr_stb && (ofs == OFS_PRESCALE);
    assign stat_we = wr_stb && (ofs == OFS_STATUS);
    assign load_we = {wr_stb && (ofs == OFS_LOAD1), wr_stb && (ofs == OFS_LOAD0)};

    // Only part of dat_i is stored for any register; fold the rest here.
    logic unused_dat;
    assign unused_dat = &{1'b0, dat_i};

    // ---------------------------------------------------------------
    // Prescaler: counts down from PRESCALE, ticks on 0, then reloads.
    // With PRESCALE = 0 the counter sits at 0 and ticks every cycle.
    // ---------------------------------------------------------------
    logic [PRESCALE_W-1:0] psc_reg;
    logic [PRESCALE_W-1:0] psc_cnt;
    logic                  tick;

    assign tick = (psc_cnt == '0);

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            psc_reg <= '0;
            psc_cnt <= '0;
        end else if (psc_we) begin
            // Restart the prescale period from the new value.
            psc_reg <= dat_i[PRESCALE_W-1:0];
            psc_cnt <= dat_i[PRESCALE_W-1:0];
        end else if (tick) begin
            psc_cnt <= psc_reg;
        end else begin
            psc_cnt <= psc_cnt - PRESCALE_W'(1);
        end
    end

    // ---------------------------------------------------------------
    // Channels
    // ---------------------------------------------------------------
    chan_ctrl_t          ctrl_wdat [NUM_CHAN];
    chan_ctrl_t          ctrl_q    [NUM_CHAN];
    logic [WIDTH-1:0]    load_q    [NUM_CHAN];
    logic [WIDTH-1:0]    count_q   [NUM_CHAN];
    logic [NUM_CHAN-1:0] expire;

    for (genvar ch = 0; ch < NUM_CHAN; ch++) begin : g_chan
        assign ctrl_wdat[ch] = '{auto_rl: dat_i[ctrl_auto_bit(ch)],
                                 en:      dat_i[ctrl_en_bit(ch)]};

        wb_timer_chan #(
            .WIDTH (WIDTH)
        ) u_chan (
            .clk      (clk),
            .arst     (arst),
            .tick     (tick),
            .ctrl_we  (ctrl_we),
            .ctrl_dat (ctrl_wdat[ch]),
            .load_we  (load_we[ch]),
            .load_dat (dat_i[WIDTH-1:0]),
            .ctrl     (ctrl_q[ch]),
            .load     (load_q[ch]),
            .count    (count_q[ch]),
            .expire   (expire[ch])
        );
    end

    // ---------------------------------------------------------------
    // STATUS and interrupts. A same-cycle expiry beats write-1-to-clear.
    // ---------------------------------------------------------------
    logic [NUM_CHAN-1:0] status_q;
    logic [NUM_CHAN-1:0] w1c_mask;

    assign w1c_mask = stat_we ? dat_i[NUM_CHAN-1:0] : '0;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            status_q <= '0;
            irq_o    <= '0;
        end else begin
            status_q <= (status_q & ~w1c_mask) | expire;
            irq_o    <= expire;
        end
    end

    // ---------------------------------------------------------------
    // Read mux and bus response
    // ---------------------------------------------------------------
    logic [31:0] rd_dat;

    always_comb begin
        rd_dat = '0;
        case (ofs)
            OFS_CTRL: begin
                rd_dat[CTRL_EN0]   = ctrl_q[0].en;
                rd_dat[CTRL_AUTO0] = ctrl_q[0].auto_rl;
                rd_dat[CTRL_EN1]   = ctrl_q[1].en;
                rd_dat[CTRL_AUTO1] = ctrl_q[1].auto_rl;
            end
            OFS_PRESCALE: rd_dat[PRESCALE_W-1:0] = psc_reg;
            OFS_LOAD0:    rd_dat[WIDTH-1:0]      = load_q[0];
            OFS_COUNT0:   rd_dat[WIDTH-1:0]      = count_q[0];
            OFS_LOAD1:    rd_dat[WIDTH-1:0]      = load_q[1];
            OFS_COUNT1:   rd_dat[WIDTH-1:0]      = count_q[1];
            OFS_STATUS: begin
                rd_dat[STATUS_EXP0] = status_q[0];
                rd_dat[STATUS_EXP1] = status_q[1];
            end
            default:      rd_dat = TIMER_ID;
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            ack_o <= 1'b0;
            dat_o <= '0;
        end else begin
            ack_o <= acc;
            dat_o <= rd_stb ? rd_dat : '0;
        end
    end

endmodule

// File: tb/tb_wb_timer.sv
// Directed self-checking bench for wb_timer: register access, periodic and
// one-shot channels, bus handshake corner cases and asynchronous reset.
module tb_wb_timer;

    localparam logic [14:0] BASE = 15'h7F00;
    localparam logic [2:0] O_CTRL = 3'd0, O_PSC = 3'd1, O_LOAD0 = 3'd2, O_COUNT0 = 3'd3;
    localparam logic [2:0] O_LOAD1 = 3'd4, O_COUNT1 = 3'd5, O_STATUS = 3'd6, O_ID = 3'd7;
    localparam logic [31:0] ID_VAL = 32'h0000_7133;

    logic        clk = 1'b0;
    logic        arst = 1'b1;
    logic [14:0] adr_i = '0;
    logic [31:0] dat_i = '0;
    logic        we_i = 1'b0;
    logic        stb_i = 1'b0;
    logic [31:0] dat_o;
    logic        ack_o;
    logic [1:0]  irq_o;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_edge = 0;
    logic [31:0] last_rd = '0;
    int irq0_n = 0;
    int irq1_n = 0;
    int irq1_at = -1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (irq_o[0]) irq0_n++;
        if (irq_o[1]) begin
            if (irq1_n == 0) irq1_at = cyc;
            irq1_n++;
        end
    end

    wb_timer #(.BASE(BASE), .WIDTH(24)) dut (
        .clk   (clk),
        .arst  (arst),
        .adr_i (adr_i),
        .dat_i (dat_i),
        .dat_o (dat_o),
        .we_i  (we_i),
        .stb_i (stb_i),
        .ack_o (ack_o),
        .irq_o (irq_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // One Wishbone transfer. at_edge > 0 aligns the committing clock edge
    // to that cycle number; records the commit edge and read data.
    task automatic wb(input logic w, input logic [2:0] o, input logic [31:0] d, input int at_edge);
        logic got;
        got = 1'b0;
        last_rd = '0;
        last_edge = -1;
        if (at_edge <= 0) begin
            @(posedge clk); #1;
        end else begin
            while (cyc < at_edge - 1) begin
                @(posedge clk); #1;
            end
        end
        adr_i = BASE | {12'd0, o};
        we_i  = w;
        dat_i = d;
        stb_i = 1'b1;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (ack_o) begin
                got = 1'b1;
                last_rd = dat_o;
                last_edge = cyc;
            end
        end
        check("ack", {31'd0, got}, 32'd1);
        @(posedge clk); #1;
        stb_i = 1'b0;
        we_i  = 1'b0;
    endtask

    task automatic wr(input logic [2:0] o, input logic [31:0] d);
        wb(1'b1, o, d, 0);
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] o, input logic [31:0] exp);
        wb(1'b0, o, 32'd0, 0);
        check(tag, last_rd, exp);
    endtask

    task automatic reset_dut();
        @(posedge clk); #1;
        arst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        arst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cycles=%0d", cyc);
        $fatal(1);
    end

    initial begin
        int ec, ep, ew, t, acks, idx;
        logic [31:0] d;
        logic [17:0] pat;
        logic got;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", {31'd0, ack_o}, 32'd0);
        check("rst_dat", dat_o, 32'd0);
        check("rst_irq", {30'd0, irq_o}, 32'd0);
        @(negedge clk);
        arst = 1'b0;

        rd_chk("id", O_ID, ID_VAL);
        rd_chk("ctrl_rst", O_CTRL, 32'd0);
        rd_chk("status_rst", O_STATUS, 32'd0);

        // Register widths and read-only offsets
        wr(O_CTRL, 32'hFFFF_FFFA);
        rd_chk("ctrl_autos", O_CTRL, 32'h0000_000A);
        wr(O_CTRL, 32'd0);
        wr(O_PSC, 32'hABCD_1234);
        rd_chk("psc_16b", O_PSC, 32'h0000_1234);
        wr(O_LOAD1, 32'hFFFF_FFFF);
        rd_chk("load1_24b", O_LOAD1, 32'h00FF_FFFF);
        rd_chk("count1_follows", O_COUNT1, 32'h00FF_FFFF);
        wr(O_COUNT1, 32'h0000_0055);
        rd_chk("count1_ro", O_COUNT1, 32'h00FF_FFFF);
        wr(O_ID, 32'd0);
        rd_chk("id_ro", O_ID, ID_VAL);
        reset_dut();

        // Channel 0 periodic: LOAD0=5, PRESCALE=0 -> pulse every 6 cycles
        wr(O_LOAD0, 32'd5);
        wr(O_PSC, 32'd0);
        wr(O_CTRL, 32'h3);
        ec = last_edge;
        pat = '0;
        for (int k = 0; k < 18; k++) begin
            @(negedge clk);
            idx = cyc - ec - 1;
            if (idx >= 0 && idx < 18 && irq_o[0]) pat[idx] = 1'b1;
        end
        check("ch0_period", {14'd0, pat}, 32'h0002_0820);
        rd_chk("ch0_status", O_STATUS, 32'h1);

        // STATUS w1c landing on an expiry edge: expiry wins
        t = ec;
        while (t <= cyc + 2) t += 6;
        wb(1'b1, O_STATUS, 32'h1, t);
        check("w1c_align", last_edge, t);
        rd_chk("exp_beats_w1c", O_STATUS, 32'h1);
        wr(O_CTRL, 32'd0);
        wr(O_STATUS, 32'h3);
        rd_chk("w1c_clears", O_STATUS, 32'd0);

        // LOAD write overrides decrement; COUNT then keeps decrementing
        wr(O_LOAD0, 32'd50);
        wr(O_CTRL, 32'h1);
        wr(O_LOAD0, 32'd40);
        ew = last_edge;
        wb(1'b0, O_COUNT0, 32'd0, 0);
        check("load_over_dec", last_rd, 32'(40 - (last_edge - ew - 1)));
        reset_dut();

        // Channel 1 one-shot: LOAD1=2, PRESCALE=3
        irq0_n = 0; irq1_n = 0; irq1_at = -1;
        wr(O_LOAD1, 32'd2);
        wr(O_PSC, 32'd3);
        ep = last_edge;
        wr(O_CTRL, 32'h4);
        ec = last_edge;
        t = ep + 4;
        while (t <= ec) t += 4;
        repeat (30) @(posedge clk);
        #1;
        check("oneshot_count", irq1_n, 32'd1);
        check("oneshot_delay", irq1_at - ep, (t + 8) - ep);
        check("oneshot_no_ch0", irq0_n, 32'd0);
        rd_chk("oneshot_en_clr", O_CTRL, 32'd0);
        rd_chk("oneshot_status", O_STATUS, 32'h2);

        // Strobe held through the ack cycle: exactly one ack
        @(posedge clk); #1;
        adr_i = BASE | {12'd0, O_ID};
        we_i = 1'b0;
        stb_i = 1'b1;
        acks = 0;
        d = '0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (ack_o) begin
                acks++;
                d = dat_o;
            end
            if (k == 1) stb_i = 1'b0;
        end
        check("held_ack_count", acks, 32'd1);
        check("held_ack_data", d, ID_VAL);

        // Unselected address: no ack, dat_o stays 0
        @(posedge clk); #1;
        adr_i = BASE + 15'd8;
        stb_i = 1'b1;
        acks = 0;
        d = '0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (ack_o) acks++;
            d = d | dat_o;
        end
        stb_i = 1'b0;
        check("unsel_no_ack", acks, 32'd0);
        check("unsel_dat_zero", d, 32'd0);

        // Reset while counting with COUNT0=3 and mid-transaction
        wr(O_LOAD0, 32'd3);
        wr(O_LOAD1, 32'd7);
        wr(O_PSC, 32'd1000);
        wr(O_CTRL, 32'h1);
        rd_chk("pre_rst_count0", O_COUNT0, 32'd3);
        @(posedge clk); #1;
        adr_i = BASE | {12'd0, O_ID};
        we_i = 1'b0;
        stb_i = 1'b1;
        @(posedge clk); #2;
        check("pre_rst_ack", {31'd0, ack_o}, 32'd1);
        arst = 1'b1;
        #1;
        check("arst_ack", {31'd0, ack_o}, 32'd0);
        check("arst_dat", dat_o, 32'd0);
        irq0_n = 0; irq1_n = 0;
        @(negedge clk);
        arst = 1'b0;
        got = 1'b0;
        d = '0;
        for (int k = 0; k < 8 && !got; k++) begin
            @(negedge clk);
            if (ack_o) begin
                got = 1'b1;
                d = dat_o;
            end
        end
        @(posedge clk); #1;
        stb_i = 1'b0;
        check("post_rst_ack", {31'd0, got}, 32'd1);
        check("post_rst_dat", d, ID_VAL);
        rd_chk("rst_ctrl", O_CTRL, 32'd0);
        rd_chk("rst_psc", O_PSC, 32'd0);
        rd_chk("rst_load0", O_LOAD0, 32'd0);
        rd_chk("rst_count0", O_COUNT0, 32'd0);
        rd_chk("rst_load1", O_LOAD1, 32'd0);
        rd_chk("rst_count1", O_COUNT1, 32'd0);
        rd_chk("rst_status", O_STATUS, 32'd0);
        repeat (20) @(posedge clk);
        #1;
        check("rst_irq_quiet", irq0_n + irq1_n, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
